// File: rtl/controle_rodada.sv
// Round sequencer for the blackjack datapath: opening deal, player hit/stay loop,
// dealer draw loop and a single registered win/lose/tie verdict.
module controle_rodada #(
  parameter int LIMITE        = 21,
  parameter int LIMITE_DEALER = 17,
  parameter int MAX_CARTAS    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       hit,
  input  logic       stay,
  input  logic       cartaok,
  input  logic [5:0] pts_jogador,
  input  logic [5:0] pts_dealer,
  output logic       pjogador,
  output logic       pdealer,
  output logic       ganhou,
  output logic       perdeu,
  output logic       empate,
  output logic       ocupado
);

  // state      | meaning
  // INICIO     | idle after reset, waiting for start
  // PEDE       | one card request held high until cartaok
  // LIBERA     | requests low, waiting for the scoring unit to release cartaok
  // DECIDE     | one cycle: pick next step from phase and fresh scores
  // VEZ_JOG    | player's turn, waiting for hit or stay
  // VEZ_DEALER | dealer draws below LIMITE_DEALER, otherwise compare
  // RESULTADO  | verdict held, waiting for start
  typedef enum logic [2:0] {
    INICIO, PEDE, LIBERA, DECIDE, VEZ_JOG, VEZ_DEALER, RESULTADO
  } estado_t;

  typedef enum logic [2:0] {
    DEAL0, DEAL1, DEAL2, DEAL3, FASE_JOG, FASE_DEALER
  } fase_t;

  localparam logic [5:0] LIM     = 6'(LIMITE);
  localparam logic [5:0] LIM_DLR = 6'(LIMITE_DEALER);
  localparam logic [3:0] MAX_C   = 4'(MAX_CARTAS);

  estado_t    estado;
  fase_t      fase;
  logic [3:0] cnt_jog;
  logic [3:0] cnt_dlr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado   <= INICIO;
      fase     <= DEAL0;
      cnt_jog  <= 4'd0;
      cnt_dlr  <= 4'd0;
      pjogador <= 1'b0;
      pdealer  <= 1'b0;
      ganhou   <= 1'b0;
      perdeu   <= 1'b0;
      empate   <= 1'b0;
      ocupado  <= 1'b0;
    end else begin
      case (estado)
        INICIO, RESULTADO: begin
          if (start) begin
            ganhou   <= 1'b0;
            perdeu   <= 1'b0;
            empate   <= 1'b0;
            cnt_jog  <= 4'd0;
            cnt_dlr  <= 4'd0;
            fase     <= DEAL0;
            ocupado  <= 1'b1;
            pjogador <= 1'b1;
            estado   <= PEDE;
          end
        end
        PEDE: begin
          if (cartaok) begin
            // the request that is still high tells which hand got the card
            if (pjogador) cnt_jog <= cnt_jog + 4'd1;
            else          cnt_dlr <= cnt_dlr + 4'd1;
            pjogador <= 1'b0;
            pdealer  <= 1'b0;
            estado   <= LIBERA;
          end
        end
        LIBERA: begin
          if (!cartaok) estado <= DECIDE;
        end
        DECIDE: begin
          case (fase)
            DEAL0: begin
              fase    <= DEAL1;
              pdealer <= 1'b1;
              estado  <= PEDE;
            end
            DEAL1: begin
              fase     <= DEAL2;
              pjogador <= 1'b1;
              estado   <= PEDE;
            end
            DEAL2: begin
              fase    <= DEAL3;
              pdealer <= 1'b1;
              estado  <= PEDE;
            end
            DEAL3: begin
              fase   <= FASE_JOG;
              estado <= VEZ_JOG;
            end
            FASE_JOG: begin
              if (pts_jogador > LIM) begin
                perdeu  <= 1'b1;
                ocupado <= 1'b0;
                estado  <= RESULTADO;
              end else if (pts_jogador == LIM || cnt_jog == MAX_C) begin
                fase   <= FASE_DEALER;
                estado <= VEZ_DEALER;
              end else begin
                estado <= VEZ_JOG;
              end
            end
            default: estado <= VEZ_DEALER;
          endcase
        end
        VEZ_JOG: begin
          // stay has priority when both buttons are pressed
          if (stay) begin
            fase   <= FASE_DEALER;
            estado <= VEZ_DEALER;
          end else if (hit) begin
            fase     <= FASE_JOG;
            pjogador <= 1'b1;
            estado   <= PEDE;
          end
        end
        VEZ_DEALER: begin
          if (pts_dealer < LIM_DLR && cnt_dlr < MAX_C) begin
            pdealer <= 1'b1;
            estado  <= PEDE;
          end else begin
            if (pts_dealer > LIM)               ganhou <= 1'b1;
            else if (pts_jogador > pts_dealer)  ganhou <= 1'b1;
            else if (pts_jogador == pts_dealer) empate <= 1'b1;
            else                                perdeu <= 1'b1;
            ocupado <= 1'b0;
            estado  <= RESULTADO;
          end
        end
        default: estado <= INICIO;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_rodada.sv
// Directed bench for controle_rodada: a scoring-unit model answers card requests
// from per-hand card queues; expected request order and verdicts are queued per round.
module tb_controle_rodada;

  logic       clock, reset, start, hit, stay, cartaok;
  logic [5:0] pts_jogador, pts_dealer;
  logic       pjogador, pdealer, ganhou, perdeu, empate, ocupado;

  int  n_vec = 0, n_fail = 0;
  int  n_req = 0, rbase = 0;
  int  hold_cyc = 1;
  logic resp_en = 1'b0;
  int  cards_p[$], cards_d[$];
  byte exp_req[$];
  logic [2:0] exp_v[$];

  localparam logic [2:0] V_GANHOU = 3'b100, V_PERDEU = 3'b010, V_EMPATE = 3'b001;

  controle_rodada dut (
    .clock(clock), .reset(reset), .start(start), .hit(hit), .stay(stay),
    .cartaok(cartaok), .pts_jogador(pts_jogador), .pts_dealer(pts_dealer),
    .pjogador(pjogador), .pdealer(pdealer), .ganhou(ganhou), .perdeu(perdeu),
    .empate(empate), .ocupado(ocupado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_reqs(input string s);
    for (int i = 0; i < s.len(); i++) exp_req.push_back(s[i]);
  endtask

  task automatic start_round();
    @(negedge clock);
    pts_jogador = 6'd0;
    pts_dealer  = 6'd0;
    rbase = n_req;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_clear", {4'd0, ganhou, perdeu, empate, ocupado}, 8'h01);
  endtask

  task automatic wait_reqs(input int n);
    int cyc = 0;
    while ((n_req - rbase) < n && cyc < 1000) begin
      @(negedge clock);
      cyc++;
    end
    check("wait_req", {7'd0, (n_req - rbase) >= n}, 8'd1);
  endtask

  task automatic wait_result();
    int cyc = 0;
    logic [2:0] ev;
    while (ocupado && cyc < 2000) begin
      @(negedge clock);
      cyc++;
    end
    check("result_timeout", {7'd0, ocupado}, 8'd0);
    ev = exp_v.pop_front();
    check("verdict", {5'd0, ganhou, perdeu, empate}, {5'd0, ev});
    check("reqs_left", 8'(exp_req.size()), 8'd0);
    repeat (4) @(negedge clock);
    check("verdict_held", {3'd0, ganhou, perdeu, empate, pjogador | pdealer, ocupado},
          {3'd0, ev, 2'b00});
  endtask

  // scoring-unit model: cartaok two cycles after a request, held hold_cyc cycles
  initial begin
    logic is_p;
    byte  ch, e;
    cartaok = 1'b0;
    forever begin
      @(negedge clock);
      if (resp_en && (pjogador || pdealer)) begin
        is_p = pjogador;
        ch   = is_p ? 8'h50 : 8'h44;
        check("req_onehot", {7'd0, pjogador & pdealer}, 8'd0);
        if (exp_req.size() == 0) check("extra_req", ch, 8'h2D);
        else begin
          e = exp_req.pop_front();
          check("req_order", ch, e);
        end
        n_req++;
        repeat (2) @(negedge clock);
        cartaok = 1'b1;
        if (is_p && cards_p.size() > 0) pts_jogador = pts_jogador + 6'(cards_p.pop_front());
        if (!is_p && cards_d.size() > 0) pts_dealer = pts_dealer + 6'(cards_d.pop_front());
        for (int i = 0; i < hold_cyc; i++) begin
          @(negedge clock);
          check("req_low_busy", {6'd0, pjogador, pdealer}, 8'd0);
        end
        cartaok = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; hit = 1'b0; stay = 1'b0;
    pts_jogador = 6'd0; pts_dealer = 6'd0;
    repeat (3) @(negedge clock);
    check("reset_state", {2'd0, pjogador, pdealer, ganhou, perdeu, empate, ocupado}, 8'h00);
    reset = 1'b0;

    // mid-PEDE reset with no scoring unit answering
    start_round();
    check("first_req", {6'd0, pjogador, pdealer}, 8'h02);
    repeat (3) @(negedge clock);
    check("req_held", {6'd0, pjogador, pdealer}, 8'h02);
    #2 reset = 1'b1;
    #1 check("async_reset", {2'd0, pjogador, pdealer, ganhou, perdeu, empate, ocupado}, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    resp_en = 1'b1;

    // 19 stay; dealer 16 draws 5 -> 21, player loses
    cards_p = '{10, 9}; cards_d = '{10, 6, 5};
    push_reqs("PDPDD"); exp_v.push_back(V_PERDEU);
    start_round();
    wait_reqs(4);
    repeat (12) @(negedge clock);
    check("deal_then_wait", {3'd0, 4'(n_req - rbase), ocupado}, {3'd0, 4'd4, 1'b1});
    stay = 1'b1;
    wait_result();
    stay = 1'b0;

    // 16 hit 10 -> 26 bust, dealer never draws
    cards_p = '{10, 6, 10}; cards_d = '{10, 7};
    push_reqs("PDPDP"); exp_v.push_back(V_PERDEU);
    start_round();
    wait_reqs(4);
    hit = 1'b1;
    wait_reqs(5);
    hit = 1'b0;
    wait_result();

    // 18 vs 18, dealer stands -> tie
    cards_p = '{10, 8}; cards_d = '{10, 8};
    push_reqs("PDPD"); exp_v.push_back(V_EMPATE);
    start_round();
    wait_reqs(4);
    stay = 1'b1;
    wait_result();
    stay = 1'b0;

    // dealer 16 draws 10 -> 26 bust, player wins
    cards_p = '{10, 8}; cards_d = '{10, 6, 10};
    push_reqs("PDPDD"); exp_v.push_back(V_GANHOU);
    start_round();
    wait_reqs(4);
    stay = 1'b1;
    wait_result();
    stay = 1'b0;

    // hit to exactly 21 ends the player turn without stay
    cards_p = '{10, 5, 6}; cards_d = '{10, 7};
    push_reqs("PDPDP"); exp_v.push_back(V_GANHOU);
    start_round();
    wait_reqs(4);
    hit = 1'b1;
    wait_reqs(5);
    hit = 1'b0;
    wait_result();

    // held hit stops at eight player cards: 16 vs 18
    cards_p = '{2, 2, 2, 2, 2, 2, 2, 2}; cards_d = '{10, 8};
    push_reqs("PDPDPPPPPP"); exp_v.push_back(V_PERDEU);
    start_round();
    wait_reqs(4);
    hit = 1'b1;
    wait_result();
    hit = 1'b0;

    // hit+stay is a stay; cartaok held 5 cycles per card; buttons ignored in RESULTADO
    hold_cyc = 5;
    cards_p = '{10, 8}; cards_d = '{10, 7};
    push_reqs("PDPD"); exp_v.push_back(V_GANHOU);
    start_round();
    wait_reqs(4);
    hit = 1'b1; stay = 1'b1;
    wait_result();
    hit = 1'b0; stay = 1'b0;
    hold_cyc = 1;

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
